// File: rtl/gx_rst_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gx_rst_pkg : state encodings and counter sizing for gx_rst_seq     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package gx_rst_pkg;

   typedef enum logic [1:0] {
      T_PD    = 2'd0,
      T_WAIT  = 2'd1,
      T_ANA   = 2'd2,
      T_READY = 2'd3
   } tx_state_e;

   typedef enum logic [1:0] {
      R_ANA   = 2'd0,
      R_LOCK  = 2'd1,
      R_READY = 2'd2
   } rx_state_e;

   // The timeout is the longest interval, so every counter is sized from it.
   function automatic int CNT_W(input int lock_timeout_cyc);
      return $clog2(lock_timeout_cyc + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/gx_rst_rx_lane.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gx_rst_rx_lane : one RX lane reset FSM (analog, lock-wait, ready)  |
// | Optional GX_RST_RELOCK_CNT_EN adds an 8-bit relock counter.        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module gx_rst_rx_lane
   import gx_rst_pkg::*;
#(
   parameter int RX_ANA_CYC       = 100,
   parameter int LOCK_STABLE_CYC  = 500,
   parameter int LOCK_TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cal_busy,
   input  logic       locked,
`ifdef GX_RST_RELOCK_CNT_EN
   output logic [7:0] relock_cnt,
`endif
   output logic       analogreset,
   output logic       digitalreset,
   output logic       ready,
   output logic       in_ready
);

   localparam int            CW          = CNT_W(LOCK_TIMEOUT_CYC);
   localparam logic [CW-1:0] ANA_LAST    = CW'(RX_ANA_CYC - 1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYC - 1);
   localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT_CYC - 1);

   rx_state_e     state;
   rx_state_e     state_nxt;
   logic [CW-1:0] tmr;
   logic [CW-1:0] stable;

   // Stable lock is tested before the timeout so it wins a same-cycle tie.
   always_comb begin
      state_nxt = state;
      case (state)
         R_ANA:   if (tmr == ANA_LAST && !cal_busy) state_nxt = R_LOCK;
         R_LOCK:  if (locked && stable == STABLE_LAST) state_nxt = R_READY;
                  else if (tmr == TMO_LAST)             state_nxt = R_ANA;
         R_READY: if (!locked) state_nxt = R_ANA;
         default: state_nxt = R_ANA;
      endcase
   end

   assign in_ready = (state == R_READY);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= R_ANA;
         tmr          <= '0;
         stable       <= '0;
         analogreset  <= 1'b1;
         digitalreset <= 1'b1;
         ready        <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state) begin
            tmr    <= '0;
            stable <= '0;
         end else begin
            case (state)
               R_ANA: begin
                  if (tmr != ANA_LAST) tmr <= tmr + 1'b1;
               end
               R_LOCK: begin
                  if (tmr != TMO_LAST) tmr <= tmr + 1'b1;
                  if (!locked)                  stable <= '0;
                  else if (stable != STABLE_LAST) stable <= stable + 1'b1;
               end
               default: begin
                  tmr    <= '0;
                  stable <= '0;
               end
            endcase
         end
         analogreset  <= (state == R_ANA);
         digitalreset <= (state != R_READY);
         ready        <= (state == R_READY);
      end
   end

`ifdef GX_RST_RELOCK_CNT_EN
   logic relock_evt;

   // Any return to R_ANA from a later state is a timeout or a lock loss.
   assign relock_evt = (state != R_ANA) && (state_nxt == R_ANA);

   always_ff @(posedge clk) begin
      if (reset)                                relock_cnt <= 8'd0;
      else if (relock_evt && relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
   end
`endif

endmodule
`default_nettype wire

// File: rtl/gx_rst_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gx_rst_seq : PLL/TX common reset sequence plus per-lane RX FSMs    |
// | Optional GX_RST_RELOCK_CNT_EN exposes per-lane relock counters.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module gx_rst_seq
   import gx_rst_pkg::*;
#(
   parameter int LANE_N           = 4,
   parameter int PLL_PD_CYC       = 50,
   parameter int TX_ANA_CYC       = 100,
   parameter int RX_ANA_CYC       = 100,
   parameter int LOCK_STABLE_CYC  = 500,
   parameter int LOCK_TIMEOUT_CYC = 50000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pll_locked_i,
   input  logic [LANE_N-1:0]   tx_cal_busy_i,
   input  logic [LANE_N-1:0]   rx_cal_busy_i,
   input  logic [LANE_N-1:0]   rx_is_lockedtodata_i,
`ifdef GX_RST_RELOCK_CNT_EN
   output logic [LANE_N*8-1:0] rx_relock_cnt_o,
`endif
   output logic                pll_powerdown_o,
   output logic [LANE_N-1:0]   tx_analogreset_o,
   output logic [LANE_N-1:0]   tx_digitalreset_o,
   output logic                tx_ready_o,
   output logic [LANE_N-1:0]   rx_analogreset_o,
   output logic [LANE_N-1:0]   rx_digitalreset_o,
   output logic [LANE_N-1:0]   rx_ready_o,
   output logic                rx_all_ready_o
);

   localparam int            CW      = CNT_W(LOCK_TIMEOUT_CYC);
   localparam logic [CW-1:0] PD_LAST = CW'(PLL_PD_CYC - 1);
   localparam logic [CW-1:0] TA_LAST = CW'(TX_ANA_CYC - 1);

   tx_state_e         tx_state;
   tx_state_e         tx_nxt;
   logic [CW-1:0]     tx_cnt;
   logic              tx_ok;
   logic [LANE_N-1:0] rx_in_ready;

   assign tx_ok = pll_locked_i & ~|tx_cal_busy_i;

   // A lost PLL lock or new calibration falls back to T_WAIT, never to T_PD.
   always_comb begin
      tx_nxt = tx_state;
      case (tx_state)
         T_PD:    if (tx_cnt == PD_LAST) tx_nxt = T_WAIT;
         T_WAIT:  if (tx_ok) tx_nxt = T_ANA;
         T_ANA:   if (!tx_ok) tx_nxt = T_WAIT;
                  else if (tx_cnt == TA_LAST) tx_nxt = T_READY;
         T_READY: if (!tx_ok) tx_nxt = T_WAIT;
         default: tx_nxt = T_PD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state          <= T_PD;
         tx_cnt            <= '0;
         pll_powerdown_o   <= 1'b1;
         tx_analogreset_o  <= '1;
         tx_digitalreset_o <= '1;
         tx_ready_o        <= 1'b0;
         rx_all_ready_o    <= 1'b0;
      end else begin
         tx_state <= tx_nxt;
         if (tx_nxt != tx_state)
            tx_cnt <= '0;
         else if ((tx_state == T_PD  && tx_cnt != PD_LAST) ||
                  (tx_state == T_ANA && tx_cnt != TA_LAST))
            tx_cnt <= tx_cnt + 1'b1;
         pll_powerdown_o   <= (tx_state == T_PD);
         tx_analogreset_o  <= {LANE_N{(tx_state == T_PD) || (tx_state == T_WAIT)}};
         tx_digitalreset_o <= {LANE_N{tx_state != T_READY}};
         tx_ready_o        <= (tx_state == T_READY);
         rx_all_ready_o    <= &rx_in_ready;
      end
   end

   for (genvar l = 0; l < LANE_N; l++) begin : g_lane
      gx_rst_rx_lane #(
         .RX_ANA_CYC       (RX_ANA_CYC),
         .LOCK_STABLE_CYC  (LOCK_STABLE_CYC),
         .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC)
      ) u_lane (
         .clk          (clk),
         .reset        (reset),
         .cal_busy     (rx_cal_busy_i[l]),
         .locked       (rx_is_lockedtodata_i[l]),
`ifdef GX_RST_RELOCK_CNT_EN
         .relock_cnt   (rx_relock_cnt_o[l*8 +: 8]),
`endif
         .analogreset  (rx_analogreset_o[l]),
         .digitalreset (rx_digitalreset_o[l]),
         .ready        (rx_ready_o[l]),
         .in_ready     (rx_in_ready[l])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_gx_rst_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_gx_rst_seq : bring-up table plus corner-case sequences          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_gx_rst_seq;

   localparam int TP_PD = 0, TP_WAIT = 1, TP_ANA = 2, TP_RDY = 3;
   localparam int RP_ANA = 0, RP_LOCK = 1, RP_RDY = 2;

   typedef struct packed {
      logic       pd;
      logic [3:0] tx_ana;
      logic [3:0] tx_dig;
      logic       tx_rdy;
      logic [3:0] rx_ana;
      logic [3:0] rx_dig;
      logic [3:0] rx_rdy;
      logic       all_rdy;
   } out_t;

   typedef struct {
      string name;
      out_t  exp;
   } sb_t;

   // Breakpoint record: inputs and expected phases hold from cycle k onward.
   typedef struct {
      int         k;
      logic       pll;
      logic [3:0] lock;
      int         tp;
      int         rp;
   } vec_t;

   logic       clk;
   logic       reset;
   logic       pll_locked;
   logic [3:0] tx_cal;
   logic [3:0] rx_cal;
   logic [3:0] rx_lock;
   logic       pll_powerdown;
   logic [3:0] tx_analogreset;
   logic [3:0] tx_digitalreset;
   logic       tx_ready;
   logic [3:0] rx_analogreset;
   logic [3:0] rx_digitalreset;
   logic [3:0] rx_ready;
   logic       rx_all_ready;
`ifdef GX_RST_RELOCK_CNT_EN
   logic [31:0] relock_cnt;
`endif

   int   vectors     = 0;
   int   miscompares = 0;
   sb_t  sbq[$];
   vec_t tbl[5];

   gx_rst_seq #(
      .LANE_N           (4),
      .PLL_PD_CYC       (4),
      .TX_ANA_CYC       (8),
      .RX_ANA_CYC       (4),
      .LOCK_STABLE_CYC  (6),
      .LOCK_TIMEOUT_CYC (20)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .pll_locked_i         (pll_locked),
      .tx_cal_busy_i        (tx_cal),
      .rx_cal_busy_i        (rx_cal),
      .rx_is_lockedtodata_i (rx_lock),
`ifdef GX_RST_RELOCK_CNT_EN
      .rx_relock_cnt_o      (relock_cnt),
`endif
      .pll_powerdown_o      (pll_powerdown),
      .tx_analogreset_o     (tx_analogreset),
      .tx_digitalreset_o    (tx_digitalreset),
      .tx_ready_o           (tx_ready),
      .rx_analogreset_o     (rx_analogreset),
      .rx_digitalreset_o    (rx_digitalreset),
      .rx_ready_o           (rx_ready),
      .rx_all_ready_o       (rx_all_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic out_t mk(input int tp, input int r0, input int r1, input int r2, input int r3);
      out_t o;
      int   rp[4];
      rp       = '{r0, r1, r2, r3};
      o.pd     = (tp == TP_PD);
      o.tx_ana = (tp == TP_PD || tp == TP_WAIT) ? 4'hF : 4'h0;
      o.tx_dig = (tp != TP_RDY) ? 4'hF : 4'h0;
      o.tx_rdy = (tp == TP_RDY);
      for (int l = 0; l < 4; l++) begin
         o.rx_ana[l] = (rp[l] == RP_ANA);
         o.rx_dig[l] = (rp[l] != RP_RDY);
         o.rx_rdy[l] = (rp[l] == RP_RDY);
      end
      o.all_rdy = &o.rx_rdy;
      return o;
   endfunction

   function automatic out_t sample();
      out_t o;
      o.pd      = pll_powerdown;
      o.tx_ana  = tx_analogreset;
      o.tx_dig  = tx_digitalreset;
      o.tx_rdy  = tx_ready;
      o.rx_ana  = rx_analogreset;
      o.rx_dig  = rx_digitalreset;
      o.rx_rdy  = rx_ready;
      o.all_rdy = rx_all_ready;
      return o;
   endfunction

   // Cycle k = k-th edge after reset is released. Outputs trail the state by
   // one edge: PD for 4, WAIT for 1, ANA for 8, then ready at 14.
   function automatic int tx_ph(input int k);
      if (k <= 4)  return TP_PD;
      if (k == 5)  return TP_WAIT;
      if (k <= 13) return TP_ANA;
      return TP_RDY;
   endfunction

   // RX analog for 4, stable lock for 6, ready at 11.
   function automatic int rx_ph(input int k);
      if (k <= 4)  return RP_ANA;
      if (k <= 10) return RP_LOCK;
      return RP_RDY;
   endfunction

   task automatic pop_check();
      sb_t  s;
      out_t a;
      s = sbq.pop_front();
      a = sample();
      vectors++;
      if (a !== s.exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", s.name, a, s.exp);
      end
   endtask

   task automatic step(input bit chk, input string name, input out_t e);
      if (chk) sbq.push_back('{name, e});
      @(posedge clk);
      #1;
      if (chk) pop_check();
   endtask

`ifdef GX_RST_RELOCK_CNT_EN
   task automatic check_relock(input string name, input logic [31:0] e);
      vectors++;
      if (relock_cnt !== e) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", name, relock_cnt, e);
      end
   endtask
`endif

   task automatic do_reset(input string tag);
      reset      = 1'b1;
      pll_locked = 1'b1;
      tx_cal     = 4'h0;
      rx_cal     = 4'h0;
      rx_lock    = 4'hF;
      step(0, "", mk(TP_PD, RP_ANA, RP_ANA, RP_ANA, RP_ANA));
      step(0, "", mk(TP_PD, RP_ANA, RP_ANA, RP_ANA, RP_ANA));
      step(1, {tag, "_reset_state"}, mk(TP_PD, RP_ANA, RP_ANA, RP_ANA, RP_ANA));
      reset = 1'b0;
   endtask

   task automatic run_bringup(input string tag);
      int idx;
      idx = 0;
      for (int k = 1; k <= 16; k++) begin
         if (idx < 4 && k >= tbl[idx+1].k) idx++;
         pll_locked = tbl[idx].pll;
         rx_lock    = tbl[idx].lock;
         step(1, $sformatf("%s_k%0d", tag, k),
              mk(tbl[idx].tp, tbl[idx].rp, tbl[idx].rp, tbl[idx].rp, tbl[idx].rp));
      end
   endtask

   initial begin
      int r;
      tbl[0] = '{1,  1'b1, 4'hF, TP_PD,   RP_ANA};
      tbl[1] = '{5,  1'b1, 4'hF, TP_WAIT, RP_LOCK};
      tbl[2] = '{6,  1'b1, 4'hF, TP_ANA,  RP_LOCK};
      tbl[3] = '{11, 1'b1, 4'hF, TP_ANA,  RP_RDY};
      tbl[4] = '{14, 1'b1, 4'hF, TP_RDY,  RP_RDY};

      // Clean bring-up.
      do_reset("bringup");
      run_bringup("bringup");

      // One-cycle PLL lock drop in T_READY; RX must be untouched.
      for (int k = 17; k <= 20; k++)
         step(1, "steady", mk(TP_RDY, RP_RDY, RP_RDY, RP_RDY, RP_RDY));
      pll_locked = 1'b0;
      step(1, "plldrop_d1", mk(TP_RDY, RP_RDY, RP_RDY, RP_RDY, RP_RDY));
      pll_locked = 1'b1;
      step(1, "plldrop_d2", mk(TP_WAIT, RP_RDY, RP_RDY, RP_RDY, RP_RDY));
      for (int d = 3; d <= 10; d++)
         step(1, $sformatf("plldrop_d%0d", d), mk(TP_ANA, RP_RDY, RP_RDY, RP_RDY, RP_RDY));
      step(1, "plldrop_d11", mk(TP_RDY, RP_RDY, RP_RDY, RP_RDY, RP_RDY));

      // Lane 2 lock toggles every 4 cycles: never 6 stable, times out after 20.
      do_reset("toggle");
      for (int k = 1; k <= 29; k++) begin
         int p2;
         rx_lock[2] = (((k - 1) / 4) % 2) == 0;
         if (k <= 4)       p2 = RP_ANA;
         else if (k <= 24) p2 = RP_LOCK;
         else if (k <= 28) p2 = RP_ANA;
         else              p2 = RP_LOCK;
         r = rx_ph(k);
         step(k == 11 || k == 24 || k == 25 || k == 28 || k == 29,
              $sformatf("toggle_k%0d", k), mk(tx_ph(k), r, r, p2, r));
`ifdef GX_RST_RELOCK_CNT_EN
         if (k == 23) check_relock("relock_before_timeout", 32'h0000_0000);
         if (k == 26) check_relock("relock_after_timeout", 32'h0001_0000);
`endif
      end

      // Lane 1 loses lock for one cycle in R_READY.
      do_reset("loss");
      for (int k = 1; k <= 20; k++)
         step(k == 20, "loss_pre", mk(tx_ph(k), rx_ph(k), rx_ph(k), rx_ph(k), rx_ph(k)));
`ifdef GX_RST_RELOCK_CNT_EN
      check_relock("relock_cleared_by_reset", 32'h0000_0000);
`endif
      rx_lock[1] = 1'b0;
      step(1, "loss_d1", mk(TP_RDY, RP_RDY, RP_RDY, RP_RDY, RP_RDY));
      rx_lock[1] = 1'b1;
      for (int d = 2; d <= 12; d++) begin
         int p1;
         if (d <= 5)       p1 = RP_ANA;
         else if (d <= 11) p1 = RP_LOCK;
         else              p1 = RP_RDY;
         step(d == 2 || d == 5 || d == 6 || d == 11 || d == 12,
              $sformatf("loss_d%0d", d), mk(TP_RDY, RP_RDY, p1, RP_RDY, RP_RDY));
      end
`ifdef GX_RST_RELOCK_CNT_EN
      check_relock("relock_lane1", 32'h0000_0100);
`endif

      // RX calibration busy on lane 0 for the first 10 cycles.
      do_reset("cal");
      for (int k = 1; k <= 19; k++) begin
         int p0;
         rx_cal[0] = (k <= 10);
         if (k <= 11)      p0 = RP_ANA;
         else if (k <= 17) p0 = RP_LOCK;
         else              p0 = RP_RDY;
         r = rx_ph(k);
         step(k == 4 || k == 11 || k == 12 || k == 17 || k == 18,
              $sformatf("cal_k%0d", k), mk(tx_ph(k), p0, r, r, r));
      end
      rx_cal = 4'h0;

      // Reset pulse while TX is in T_ANA and RX in R_LOCK.
      do_reset("mid");
      for (int k = 1; k <= 7; k++)
         step(k == 7, "mid_pre", mk(tx_ph(k), rx_ph(k), rx_ph(k), rx_ph(k), rx_ph(k)));
      reset = 1'b1;
      step(1, "mid_reset", mk(TP_PD, RP_ANA, RP_ANA, RP_ANA, RP_ANA));
      reset = 1'b0;
      run_bringup("restart");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
